vx_wb_arbiter: RTL
==================

Name: vx_wb_arbiter

Overview:
- Shares the single register-file writeback port between the commit sources (ALU, LSU-load, CSR, FPU, GPU).
- Uses round-robin arbitration with per-packet grant locking, so multi-beat results (eop-delimited) are never interleaved.
- Drives a registered writeback output with valid/ready backpressure.
- Emits a registered per-commit thread count for the CSR instret/commit counters.
- Sits between the execute-unit commit interfaces and the issue-stage register file and scoreboard.

Parameters:
- NUM_REQS, 5: number of commit requesters; index 0 has first priority after reset.
- NUM_THREADS, 4: threads per warp.
- NW_BITS, 2: warp-id width.
- XLEN, 32: data and PC width.
- RD_BITS, 5: destination register index width.

Ports:
- clk  in  1: clock, all state on rising edge.
- reset_n  in  1: asynchronous active-low reset.
- req_valid  in  NUM_REQS: per-requester valid.
- req_ready  out  NUM_REQS: per-requester ready (combinational).
- req_wid  in  NUM_REQS*NW_BITS: warp id, flattened with requester i at slice i.
- req_pc  in  NUM_REQS*XLEN: instruction PC.
- req_tmask  in  NUM_REQS*NUM_THREADS: thread mask.
- req_wb  in  NUM_REQS: register write enable.
- req_rd  in  NUM_REQS*RD_BITS: destination register.
- req_data  in  NUM_REQS*NUM_THREADS*XLEN: per-thread result.
- req_eop  in  NUM_REQS: last beat of packet.
- wb_valid  out  1: writeback beat valid.
- wb_ready  in  1: consumer accepts beat.
- wb_wid, wb_pc, wb_tmask, wb_wb, wb_rd, wb_data, wb_eop  out  (matching single-slice widths): registered beat fields.
- cmt_valid  out  1: one-cycle pulse per completed packet.
- cmt_size  out  $clog2(NUM_THREADS+1): popcount of the tmask of the committed eop beat.

Behaviour:
- Reset (async assert, sync release): wb_valid=0; all wb_* fields=0; cmt_valid=0; cmt_size=0; rr_ptr=NUM_REQS-1; lock=0; lock_idx=0. An in-flight locked packet is abandoned; no outputs are produced for it after reset.
- Load enable: load_en = !wb_valid || wb_ready. This gives a single-stage pipe with full throughput of 1 beat/cycle under continuous wb_ready.
- Eligibility:
  - If lock=1, only requester lock_idx is eligible.
  - Otherwise every requester with req_valid=1 is eligible.
- Grant: the first eligible index searching (rr_ptr+1) mod NUM_REQS upward with wrap. The grant is one-hot or zero.
- req_ready[i] = grant[i] && load_en. No requester ever sees ready while the output register is stalled.
- Fire: accept = |(req_valid & req_ready). On accept, the granted slice's fields are registered into wb_* and wb_valid=1 next cycle.
- If load_en=1 and there is no accept, wb_valid=0 next cycle.
- If load_en=0, all wb_* fields hold stable.
- Pointer and lock updates on accept of index g:
  - rr_ptr<=g.
  - If req_eop[g]=0: lock<=1 and lock_idx<=g.
  - If req_eop[g]=1: lock<=0.
  - rr_ptr is unchanged when there is no accept.
- Lock persists across idle cycles of the locked requester. Other requesters starve until its eop beat fires.
- Commit count: cmt_valid<=accept && eop of the granted beat, and cmt_size<=popcount(granted tmask). Both are registered, so they appear in the same cycle wb_valid rises for that beat.
  - Counting is independent of wb_ready stalls.
  - tmask=0 gives cmt_size=0 with cmt_valid=1.
- req_wb=0 beats (stores, fences) are arbitrated and forwarded identically; the consumer ignores them for register writes.
- No combinational path from wb_ready to any wb_* output. req_ready depends combinationally on wb_ready, req_valid and state only.
- Requesters must hold fields stable while valid && !ready; the block does not check this.

Test Plan:
- Single beat: req1 valid, eop=1, tmask=4'b1011, rd=7, wb_ready=1. Expected: req_ready[1]=1 in the same cycle; next cycle wb_valid=1, wb_rd=7, cmt_valid=1, cmt_size=3; the following cycle wb_valid=0.
- Round-robin fairness: all 5 requesters hold valid with eop=1 continuously, wb_ready=1. Expected grant order is 0,1,2,3,4,0,1,..., one beat per cycle with no bubbles.
- Backpressure: wb_ready=0 for 3 cycles with a beat held. Expected: wb_* stays stable, all req_ready=0, and rr_ptr is unchanged. On wb_ready=1 the next grant proceeds with no beat lost or duplicated.
- Packet lock: req2 sends 3 beats (eop=0,0,1) with a 1-cycle gap between beats, while req0 and req3 stay valid. Expected: req0 and req3 are not granted until req2's eop fires, then req3 is granted next (pointer=2). cmt_valid pulses once with the size of the eop beat.
- Async reset mid-packet: req4 is locked after its first beat and reset_n is pulsed low between clock edges. Expected: wb_valid, cmt_valid and lock clear immediately. After release, with req0 and req4 both valid, req0 is granted first.
- Wrap boundary: rr_ptr=4, with only req4 and req0 valid. Expected grant is req0, then req4.

Source files
------------

// File: rtl/vx_wb_arbiter.sv
// Writeback arbiter: round-robin shares the register-file writeback port between
// commit sources, locks the grant for a whole eop-delimited packet and registers the beat.
module vx_wb_arbiter #(
  parameter int NUM_REQS    = 5,
  parameter int NUM_THREADS = 4,
  parameter int NW_BITS     = 2,
  parameter int XLEN        = 32,
  parameter int RD_BITS     = 5
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [NUM_REQS-1:0]                  req_valid,
  output logic [NUM_REQS-1:0]                  req_ready,
  input  logic [NUM_REQS*NW_BITS-1:0]          req_wid,
  input  logic [NUM_REQS*XLEN-1:0]             req_pc,
  input  logic [NUM_REQS*NUM_THREADS-1:0]      req_tmask,
  input  logic [NUM_REQS-1:0]                  req_wb,
  input  logic [NUM_REQS*RD_BITS-1:0]          req_rd,
  input  logic [NUM_REQS*NUM_THREADS*XLEN-1:0] req_data,
  input  logic [NUM_REQS-1:0]                  req_eop,
  output logic                                 wb_valid,
  input  logic                                 wb_ready,
  output logic [NW_BITS-1:0]                   wb_wid,
  output logic [XLEN-1:0]                      wb_pc,
  output logic [NUM_THREADS-1:0]               wb_tmask,
  output logic                                 wb_wb,
  output logic [RD_BITS-1:0]                   wb_rd,
  output logic [NUM_THREADS*XLEN-1:0]          wb_data,
  output logic                                 wb_eop,
  output logic                                 cmt_valid,
  output logic [$clog2(NUM_THREADS+1)-1:0]     cmt_size
);
  localparam int IDX_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam int CNT_W = $clog2(NUM_THREADS+1);

  typedef struct packed {
    logic [NW_BITS-1:0]          wid;
    logic [XLEN-1:0]             pc;
    logic [NUM_THREADS-1:0]      tmask;
    logic                        wb;
    logic [RD_BITS-1:0]          rd;
    logic [NUM_THREADS*XLEN-1:0] data;
    logic                        eop;
  } beat_t;

  beat_t [NUM_REQS-1:0] req_beat;
  beat_t                sel, wb_q;
  logic [NUM_REQS-1:0]  elig, grant;
  logic [IDX_W-1:0]     rr_ptr, lock_idx, grant_idx;
  logic [CNT_W-1:0]     sel_cnt;
  logic                 lock, load_en, accept;

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_req
    assign req_beat[i] = {req_wid[i*NW_BITS +: NW_BITS],
                          req_pc[i*XLEN +: XLEN],
                          req_tmask[i*NUM_THREADS +: NUM_THREADS],
                          req_wb[i],
                          req_rd[i*RD_BITS +: RD_BITS],
                          req_data[i*NUM_THREADS*XLEN +: NUM_THREADS*XLEN],
                          req_eop[i]};
  end

  assign load_en = !wb_valid || wb_ready;

  always_comb begin
    elig = req_valid;
    if (lock) elig = req_valid & (NUM_REQS'(1) << lock_idx);
  end

  // Scan from farthest to nearest so the first eligible index after rr_ptr wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int k = NUM_REQS; k >= 1; k--) begin
      if (elig[(int'(rr_ptr) + k) % NUM_REQS]) begin
        grant = '0;
        grant[(int'(rr_ptr) + k) % NUM_REQS] = 1'b1;
        grant_idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQS);
      end
    end
  end

  assign req_ready = grant & {NUM_REQS{load_en}};
  assign accept    = |(req_valid & req_ready);
  assign sel       = req_beat[grant_idx];

  always_comb begin
    sel_cnt = '0;
    for (int t = 0; t < NUM_THREADS; t++) sel_cnt = sel_cnt + CNT_W'(sel.tmask[t]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid  <= 1'b0;
      wb_q      <= '0;
      cmt_valid <= 1'b0;
      cmt_size  <= '0;
      rr_ptr    <= IDX_W'(NUM_REQS-1);
      lock      <= 1'b0;
      lock_idx  <= '0;
    end else begin
      cmt_valid <= accept && sel.eop;
      if (load_en) begin
        wb_valid <= accept;
        if (accept) wb_q <= sel;
      end
      if (accept) begin
        rr_ptr <= grant_idx;
        lock   <= !sel.eop;
        if (!sel.eop) lock_idx <= grant_idx;
        if (sel.eop)  cmt_size <= sel_cnt;
      end
    end
  end

  assign wb_wid   = wb_q.wid;
  assign wb_pc    = wb_q.pc;
  assign wb_tmask = wb_q.tmask;
  assign wb_wb    = wb_q.wb;
  assign wb_rd    = wb_q.rd;
  assign wb_data  = wb_q.data;
  assign wb_eop   = wb_q.eop;

endmodule
